comp_bin_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one N-bit magnitude-compare datapath among R requesters.
- Each requester submits an operand pair plus a mode bit: unsigned, or two's-complement signed via MSB inversion.
- The block grants one requester, captures its operands and evaluates the compare.
- It returns Mayor/Igual/Menor flags, tagged with the requester ID, on a single shared response channel with backpressure.

---
 rtl/comp_bin_arb.sv | 138 +++++++++++++
 tb/tb_comp_bin_arb.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_bin_arb.sv
// Round-robin arbiter that lets R requesters share one N-bit magnitude comparator.
// Latency: valid seen in IDLE -> o_Ready next cycle -> response 2 cycles later; 4 cycles per compare.
// Backpressure: response held stable in RESP until i_Resp_Ready; no new grant until it drains.
module comp_bin_arb #(
  parameter int N = 8,
  parameter int R = 4,
  localparam int RW = $clog2(R)
) (
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  input  logic [R-1:0]    i_Valid,
  input  logic [R*N-1:0]  i_A,
  input  logic [R*N-1:0]  i_B,
  input  logic [R-1:0]    i_Ctrl,
  output logic [R-1:0]    o_Ready,
  output logic            o_Resp_Valid,
  input  logic            i_Resp_Ready,
  output logic [RW-1:0]   o_Resp_Id,
  output logic            o_Mayor,
  output logic            o_Igual,
  output logic            o_Menor,
  output logic            o_Busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_EVAL  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   ptr_q;
  logic [RW-1:0]   gnt_q;
  logic [N-1:0]    a_q, b_q;
  logic            mode_q;

  logic [RW-1:0]   pick;
  logic            pick_any;
  logic [RW:0]     cand;
  logic [N-1:0]    cmp_a, cmp_b;

  // Round-robin search: walk downward in offset so the lowest offset from ptr wins.
  always_comb begin
    pick     = '0;
    pick_any = 1'b0;
    cand     = '0;
    for (int i = R - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + (RW+1)'(i);
      if (cand >= (RW+1)'(R)) begin
        cand = cand - (RW+1)'(R);
      end
      if (i_Valid[cand[RW-1:0]]) begin
        pick     = cand[RW-1:0];
        pick_any = 1'b1;
      end
    end
  end

  // Signed mode flips the MSB so two's-complement order becomes unsigned order.
  always_comb begin
    cmp_a = a_q;
    cmp_b = b_q;
    if (mode_q) begin
      cmp_a[N-1] = ~a_q[N-1];
      cmp_b[N-1] = ~b_q[N-1];
    end
  end

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a withdrawn request in GRANT drops straight back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_any) state_d = S_GRANT;
      S_GRANT: state_d = i_Valid[gnt_q] ? S_EVAL : S_IDLE;
      S_EVAL:  state_d = S_RESP;
      S_RESP:  if (i_Resp_Ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant, operand capture, result and pointer registers.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ptr_q     <= '0;
      gnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      o_Resp_Id <= '0;
      o_Mayor   <= 1'b0;
      o_Igual   <= 1'b0;
      o_Menor   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_any) gnt_q <= pick;
        end
        S_GRANT: begin
          if (i_Valid[gnt_q]) begin
            a_q    <= i_A[int'(gnt_q)*N +: N];
            b_q    <= i_B[int'(gnt_q)*N +: N];
            mode_q <= i_Ctrl[gnt_q];
          end
        end
        S_EVAL: begin
          o_Mayor   <= (cmp_a > cmp_b);
          o_Igual   <= (cmp_a == cmp_b);
          o_Menor   <= (cmp_a < cmp_b);
          o_Resp_Id <= gnt_q;
        end
        S_RESP: begin
          if (i_Resp_Ready) begin
            ptr_q   <= (gnt_q == RW'(R - 1)) ? '0 : gnt_q + RW'(1);
            o_Mayor <= 1'b0;
            o_Igual <= 1'b0;
            o_Menor <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Ready      = (state_q == S_GRANT) ? (R'(1) << gnt_q) : '0;
  assign o_Resp_Valid = (state_q == S_RESP);
  assign o_Busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_comp_bin_arb.sv
// Directed bench for comp_bin_arb with a cycle-level reference model.
// Outputs compared against the model at every falling edge, plus literal spot checks.
// Drives inputs on falling edges, away from the DUT's rising-edge updates.
module tb_comp_bin_arb;
  localparam int N  = 8;
  localparam int R  = 4;
  localparam int RW = $clog2(R);

  logic            clk = 1'b0;
  logic            rst_n;
  logic [R-1:0]    valid;
  logic [R*N-1:0]  a_bus, b_bus;
  logic [R-1:0]    ctrl;
  logic [R-1:0]    ready;
  logic            resp_vld;
  logic            resp_rdy;
  logic [RW-1:0]   resp_id;
  logic            mayor, igual, menor, busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  comp_bin_arb #(.N(N), .R(R)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(valid), .i_A(a_bus), .i_B(b_bus),
    .i_Ctrl(ctrl), .o_Ready(ready), .o_Resp_Valid(resp_vld), .i_Resp_Ready(resp_rdy),
    .o_Resp_Id(resp_id), .o_Mayor(mayor), .o_Igual(igual), .o_Menor(menor), .o_Busy(busy)
  );

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 granted, 2 evaluating, 3 responding
  int m_phase = 0, m_ptr = 0, m_gnt = 0, m_a = 0, m_b = 0, m_id = 0;
  int m_mode = 0, m_mayor = 0, m_igual = 0, m_menor = 0;

  function automatic int rr_pick(int ptr, logic [R-1:0] v);
    for (int k = 0; k < R; k++) begin
      if (v[(ptr + k) % R]) return (ptr + k) % R;
    end
    return -1;
  endfunction

  function automatic int num_val(int x, int mode);
    if (mode != 0 && x >= (1 << (N - 1))) return x - (1 << N);
    return x;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_ptr <= 0; m_gnt <= 0; m_a <= 0; m_b <= 0; m_id <= 0;
      m_mode <= 0; m_mayor <= 0; m_igual <= 0; m_menor <= 0;
    end else begin
      case (m_phase)
        0: if (rr_pick(m_ptr, valid) >= 0) begin
             m_gnt   <= rr_pick(m_ptr, valid);
             m_phase <= 1;
           end
        1: if (valid[m_gnt]) begin
             m_a     <= int'(a_bus[m_gnt*N +: N]);
             m_b     <= int'(b_bus[m_gnt*N +: N]);
             m_mode  <= int'(ctrl[m_gnt]);
             m_phase <= 2;
           end else begin
             m_phase <= 0;
           end
        2: begin
             m_mayor <= int'(num_val(m_a, m_mode) >  num_val(m_b, m_mode));
             m_igual <= int'(num_val(m_a, m_mode) == num_val(m_b, m_mode));
             m_menor <= int'(num_val(m_a, m_mode) <  num_val(m_b, m_mode));
             m_id    <= m_gnt;
             m_phase <= 3;
           end
        default: if (resp_rdy) begin
             m_ptr   <= (m_gnt + 1) % R;
             m_mayor <= 0; m_igual <= 0; m_menor <= 0;
             m_phase <= 0;
           end
      endcase
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic compare_model();
    chk("cmp_ready", int'(ready), (m_phase == 1) ? (1 << m_gnt) : 0);
    chk("cmp_resp_vld", int'(resp_vld), int'(m_phase == 3));
    chk("cmp_busy", int'(busy), int'(m_phase != 0));
    chk("cmp_resp_id", int'(resp_id), m_id);
    chk("cmp_mayor", int'(mayor), m_mayor);
    chk("cmp_igual", int'(igual), m_igual);
    chk("cmp_menor", int'(menor), m_menor);
  endtask

  // ---------------- stimulus helpers ----------------
  bit          auto_drop = 1'b0;
  logic [R-1:0] prev_ready = '0;

  task automatic step();
    @(negedge clk);
    cyc++;
    compare_model();
    if (auto_drop) valid = valid & ~prev_ready;
    prev_ready = ready;
  endtask

  task automatic set_req(input int k, input int a, input int b, input bit c);
    a_bus[k*N +: N] = N'(a);
    b_bus[k*N +: N] = N'(b);
    ctrl[k]         = c;
  endtask

  // Single requester served start to finish with response consumer ready.
  task automatic serve_one(input string nm, input int k, input int a, input int b, input bit c,
                           input int em, input int ei, input int el);
    set_req(k, a, b, c);
    valid    = '0;
    valid[k] = 1'b1;
    step();
    chk({nm, "_ready"}, int'(ready), 1 << k);
    step();
    valid = '0;
    step();
    chk({nm, "_resp_vld"}, int'(resp_vld), 1);
    chk({nm, "_resp_id"}, int'(resp_id), k);
    chk({nm, "_mayor"}, int'(mayor), em);
    chk({nm, "_igual"}, int'(igual), ei);
    chk({nm, "_menor"}, int'(menor), el);
    step();
    chk({nm, "_idle"}, int'(busy), 0);
  endtask

  int gq[$];
  int rq[$];
  int rc[$];
  int exp_ord[5] = '{0, 1, 2, 3, 0};
  bit reraised;

  initial begin
    rst_n = 1'b0; valid = '0; a_bus = '0; b_bus = '0; ctrl = '0; resp_rdy = 1'b1;
    repeat (3) step();
    chk("rst_ready", int'(ready), 0);
    chk("rst_resp_vld", int'(resp_vld), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_flags", int'({mayor, igual, menor}), 0);
    chk("rst_resp_id", int'(resp_id), 0);
    rst_n = 1'b1;
    step();

    // Compare modes; requester order leaves the pointer at 0 afterwards.
    serve_one("uns_80_7f", 2, 'h80, 'h7F, 1'b0, 1, 0, 0);
    serve_one("sgn_80_7f", 2, 'h80, 'h7F, 1'b1, 0, 0, 1);
    serve_one("uns_eq55",  1, 'h55, 'h55, 1'b0, 0, 1, 0);
    serve_one("sgn_7f_81", 0, 'h7F, 'h81, 1'b1, 1, 0, 0);
    serve_one("sgn_eq55",  3, 'h55, 'h55, 1'b1, 0, 1, 0);

    // Fairness: all four valid, requester 0 re-requests once its response shows.
    for (int k = 0; k < R; k++) set_req(k, k * 'h10, 'h20, 1'b0);
    valid = '1; auto_drop = 1'b1; reraised = 1'b0;
    repeat (24) begin
      step();
      for (int k = 0; k < R; k++) if (ready[k]) gq.push_back(k);
      if (resp_vld) begin
        rq.push_back(int'(resp_id));
        rc.push_back(cyc);
        if (resp_id == 0 && !reraised) begin
          valid[0] = 1'b1;
          reraised = 1'b1;
        end
      end
    end
    auto_drop = 1'b0; valid = '0;
    chk("fair_grant_count", gq.size(), 5);
    chk("fair_resp_count", rq.size(), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++) chk("fair_grant_order", gq[i], exp_ord[i]);
    for (int i = 0; i < 5 && i < rq.size(); i++) chk("fair_resp_order", rq[i], exp_ord[i]);
    for (int i = 1; i < rc.size(); i++) chk("fair_resp_spacing", rc[i] - rc[i-1], 4);

    // Backpressure: pointer is 1, serve requester 2 with the consumer stalled.
    step();
    resp_rdy = 1'b0;
    set_req(2, 'h10, 'h20, 1'b0);
    valid = 4'b0100;
    step();
    chk("bp_ready", int'(ready), 4'b0100);
    step();
    valid = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_vld", int'(resp_vld), 1);
      chk("bp_resp_id", int'(resp_id), 2);
      chk("bp_flags", int'({mayor, igual, menor}), 3'b001);
      if (i == 2) begin
        set_req(0, 'h01, 'h01, 1'b0);
        set_req(3, 'hFF, 'h01, 1'b1);
        valid = 4'b1101;
      end
      step();
    end
    resp_rdy = 1'b1;
    step();
    chk("bp_drained", int'(busy), 0);
    step();
    chk("bp_ptr_advanced", int'(ready), 4'b1000);
    step();
    valid = '0;
    step();
    chk("bp_next_flags", int'({mayor, igual, menor}), 3'b001);
    step();

    // Withdrawal: pointer moves to 1, then requester 1 drops out in its grant cycle.
    serve_one("pre_wd", 0, 'h01, 'h02, 1'b0, 0, 0, 1);
    valid = 4'b0010;
    step();
    chk("wd_ready", int'(ready), 4'b0010);
    valid = '0;
    step();
    chk("wd_idle", int'(busy), 0);
    chk("wd_no_resp", int'(resp_vld), 0);
    step();
    chk("wd_stay_idle", int'(busy), 0);
    set_req(1, 'h33, 'h22, 1'b0);
    set_req(0, 'h00, 'h00, 1'b0);
    valid = 4'b0011;
    step();
    chk("wd_next_grant", int'(ready), 4'b0010);
    step();
    valid = '0;
    step();
    chk("wd_next_id", int'(resp_id), 1);
    chk("wd_next_mayor", int'(mayor), 1);
    step();

    // Reset during EVAL, then the first grant must follow a pointer of 0.
    set_req(3, 'h05, 'h06, 1'b0);
    valid = 4'b1000;
    step();
    chk("mid_ready", int'(ready), 4'b1000);
    step();
    valid = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_resp_vld", int'(resp_vld), 0);
    chk("mid_rst_ready", int'(ready), 0);
    chk("mid_rst_flags", int'({mayor, igual, menor}), 0);
    step();
    rst_n = 1'b1;
    set_req(1, 'h01, 'h01, 1'b1);
    set_req(3, 'h09, 'h01, 1'b0);
    valid = 4'b1010;
    step();
    chk("post_rst_grant", int'(ready), 4'b0010);
    step();
    valid = '0;
    step();
    chk("post_rst_id", int'(resp_id), 1);
    chk("post_rst_igual", int'(igual), 1);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
